// File: rtl/jesd204b_link_tx.sv
// JESD204B single-lane link-layer transmitter: CGS /K/ stream, ILAS sequence
// and DATA with either frame-end character replacement or self-synchronous scrambling.
module jesd204b_link_tx #(
    parameter int OCTETS_PER_BEAT = 4,
    parameter int F               = 2,
    parameter int K               = 16,
    parameter int ILAS_MF         = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         lmfc,
    input  logic                         sync_n,
    input  logic                         scramble_en,
    input  logic [111:0]                 cfg,
    input  logic [8*OCTETS_PER_BEAT-1:0] in_data,
    output logic                         in_ready,
    output logic [8*OCTETS_PER_BEAT-1:0] out_data,
    output logic [OCTETS_PER_BEAT-1:0]   out_ctrl,
    output logic [1:0]                   link_state
);

    localparam int FK = F * K;
    localparam int PW = $clog2(FK);

    if (!((OCTETS_PER_BEAT == 4) || (OCTETS_PER_BEAT == 8)) ||
        !((F == 1) || (F == 2) || (F == 4) || (F == 8)) ||
        ((FK % OCTETS_PER_BEAT) != 0) || (FK < 20) ||
        (ILAS_MF < 2) || (ILAS_MF > 8)) begin : g_bad_params
        $error("jesd204b_link_tx: illegal parameter combination");
    end

    typedef enum logic [1:0] {CGS = 2'd0, ILAS = 2'd1, DATA = 2'd2} state_t;

    state_t                       state, state_nxt;
    logic                         wait_lmfc;
    logic [PW-1:0]                pos, pos_nxt;
    logic [3:0]                   mf, mf_nxt;
    logic [2:0]                   low_cnt;
    logic [7:0]                   prev, prev_nxt;
    logic                         prev_rep, prev_rep_nxt;
    logic [14:0]                  scr, scr_nxt;
    logic                         scr_on, scr_on_nxt;
    logic [8*OCTETS_PER_BEAT-1:0] data_nxt;
    logic [OCTETS_PER_BEAT-1:0]   ctrl_nxt;
    logic                         lost, start, ilas_done, to_data;

    // pos is the multiframe octet index of the beat about to be produced.
    assign lost       = (state != CGS) && (low_cnt == 3'd4);
    assign start      = (state == CGS) && wait_lmfc && sync_n && lmfc;
    assign ilas_done  = (mf == 4'(ILAS_MF));
    assign to_data    = !lost && ((state == DATA) || ((state == ILAS) && ilas_done));
    assign in_ready   = to_data;
    assign link_state = state;

    always_comb begin : next_beat
        int         base, nb, j;
        logic [3:0] m;
        logic [7:0] d, o, p;
        logic       r, on;
        logic [14:0] s;
        state_nxt    = state;
        pos_nxt      = pos;
        mf_nxt       = mf;
        prev_nxt     = prev;
        prev_rep_nxt = prev_rep;
        scr_nxt      = scr;
        scr_on_nxt   = scr_on;
        data_nxt     = {OCTETS_PER_BEAT{8'hBC}};
        ctrl_nxt     = '1;
        base = start ? 0 : int'(pos);
        m    = start ? 4'd0 : mf;
        nb   = base + OCTETS_PER_BEAT;
        j    = 0;
        d    = '0;
        o    = '0;
        p    = prev;
        r    = prev_rep;
        on   = scr_on;
        s    = scr;
        if (lost) begin
            state_nxt = CGS;
        end else if (start || ((state == ILAS) && !ilas_done)) begin
            state_nxt    = ILAS;
            pos_nxt      = (nb == FK) ? '0 : PW'(nb);
            mf_nxt       = (nb == FK) ? m + 4'd1 : m;
            prev_nxt     = 8'h7C;
            prev_rep_nxt = 1'b1;
            scr_nxt      = 15'h7F80;
            for (int i = 0; i < OCTETS_PER_BEAT; i++) begin
                j           = base + i;
                o           = 8'(j);
                ctrl_nxt[i] = 1'b0;
                if (j == 0) begin
                    o           = 8'h1C;
                    ctrl_nxt[i] = 1'b1;
                end else if (j == FK - 1) begin
                    o           = 8'h7C;
                    ctrl_nxt[i] = 1'b1;
                end else if ((m == 4'd1) && (j == 1)) begin
                    o           = 8'h9C;
                    ctrl_nxt[i] = 1'b1;
                end else if (m == 4'd1) begin
                    for (int c = 0; c < 14; c++) begin
                        if (j == c + 2) o = cfg[8*c +: 8];
                    end
                end
                data_nxt[8*i +: 8] = o;
            end
        end else if (to_data) begin
            // scramble_en only matters on the first DATA beat; afterwards the latched copy rules.
            on         = (state == ILAS) ? scramble_en : scr_on;
            scr_on_nxt = on;
            state_nxt  = DATA;
            pos_nxt    = (nb == FK) ? '0 : PW'(nb);
            for (int i = 0; i < OCTETS_PER_BEAT; i++) begin
                j           = base + i;
                d           = in_data[8*i +: 8];
                o           = d;
                ctrl_nxt[i] = 1'b0;
                if (on) begin
                    for (int b = 7; b >= 0; b--) begin
                        o[b] = d[b] ^ s[13] ^ s[14];
                        s    = {s[13:0], o[b]};
                    end
                    ctrl_nxt[i] = ((j % F) == F - 1) &&
                                  ((o == 8'hFC) || ((j == FK - 1) && (o == 8'h7C)));
                end else if ((j % F) == F - 1) begin
                    if ((j == FK - 1) && (d == p)) begin
                        o           = 8'h7C;
                        ctrl_nxt[i] = 1'b1;
                        r           = 1'b1;
                    end else if ((j != FK - 1) && (d == p) && !r) begin
                        o           = 8'hFC;
                        ctrl_nxt[i] = 1'b1;
                        r           = 1'b1;
                    end else begin
                        r = 1'b0;
                    end
                    p = d;
                end
                data_nxt[8*i +: 8] = o;
            end
            prev_nxt     = p;
            prev_rep_nxt = r;
            scr_nxt      = s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CGS;
            wait_lmfc <= 1'b0;
            pos       <= '0;
            mf        <= '0;
            low_cnt   <= '0;
            prev      <= '0;
            prev_rep  <= 1'b0;
            scr       <= '0;
            scr_on    <= 1'b0;
            out_data  <= {OCTETS_PER_BEAT{8'hBC}};
            out_ctrl  <= '1;
        end else begin
            state     <= state_nxt;
            wait_lmfc <= (state == CGS) && sync_n;
            pos       <= pos_nxt;
            mf        <= mf_nxt;
            low_cnt   <= sync_n ? 3'd0 : ((low_cnt == 3'd4) ? 3'd4 : low_cnt + 3'd1);
            prev      <= prev_nxt;
            prev_rep  <= prev_rep_nxt;
            scr       <= scr_nxt;
            scr_on    <= scr_on_nxt;
            out_data  <= data_nxt;
            out_ctrl  <= ctrl_nxt;
        end
    end

endmodule

// File: tb/tb_jesd204b_link_tx.sv
// Bench for jesd204b_link_tx: default-parameter instance plus an 8-octet, F=1 instance,
// both checked against an octet-stream reference model.
module tb_jesd204b_link_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset       = 1'b1;
    logic         scramble_en = 1'b0;
    logic [111:0] cfg         = '0;

    logic        lmfc_a = 1'b0, sync_n_a = 1'b0;
    logic [31:0] in_data_a = '0;
    logic        in_ready_a;
    logic [31:0] out_data_a;
    logic [3:0]  out_ctrl_a;
    logic [1:0]  link_state_a;

    logic        lmfc_b = 1'b0, sync_n_b = 1'b0;
    logic [63:0] in_data_b = '0;
    logic        in_ready_b;
    logic [63:0] out_data_b;
    logic [7:0]  out_ctrl_b;
    logic [1:0]  link_state_b;

    jesd204b_link_tx dut (
        .clk(clk), .reset(reset), .lmfc(lmfc_a), .sync_n(sync_n_a),
        .scramble_en(scramble_en), .cfg(cfg), .in_data(in_data_a),
        .in_ready(in_ready_a), .out_data(out_data_a), .out_ctrl(out_ctrl_a),
        .link_state(link_state_a)
    );

    jesd204b_link_tx #(.OCTETS_PER_BEAT(8), .F(1), .K(32), .ILAS_MF(4)) dut_wide (
        .clk(clk), .reset(reset), .lmfc(lmfc_b), .sync_n(sync_n_b),
        .scramble_en(scramble_en), .cfg(cfg), .in_data(in_data_b),
        .in_ready(in_ready_b), .out_data(out_data_b), .out_ctrl(out_ctrl_b),
        .link_state(link_state_b)
    );

    int checks = 0, errors = 0;
    int sel = 0, opb = 4, f = 2, fk = 32;

    // Reference model state: octet index in multiframe, previous frame-end octet, scrambler history.
    logic [7:0] m_prev;
    bit         m_rep, m_scr;
    bit         hist[$];
    int         m_j;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] obs_data();
        return (sel == 1) ? out_data_b : {32'h0, out_data_a};
    endfunction
    function automatic logic [7:0] obs_ctrl();
        return (sel == 1) ? out_ctrl_b : {4'h0, out_ctrl_a};
    endfunction
    function automatic logic obs_ready();
        return (sel == 1) ? in_ready_b : in_ready_a;
    endfunction
    function automatic logic [1:0] obs_state();
        return (sel == 1) ? link_state_b : link_state_a;
    endfunction
    function automatic logic [63:0] k_data();
        return (sel == 1) ? {8{8'hBC}} : {32'h0, {4{8'hBC}}};
    endfunction
    function automatic logic [7:0] k_ctrl();
        return (sel == 1) ? 8'hFF : 8'h0F;
    endfunction

    task automatic drive(input logic [63:0] d);
        if (sel == 1) in_data_b = d;
        else in_data_a = d[31:0];
    endtask
    task automatic set_sync(input logic v);
        if (sel == 1) sync_n_b = v;
        else sync_n_a = v;
    endtask
    task automatic set_lmfc(input logic v);
        if (sel == 1) lmfc_b = v;
        else lmfc_a = v;
    endtask

    function automatic logic [63:0] gen(input int mode);
        logic [63:0] v;
        v = '0;
        case (mode)
            0: v = {$urandom, $urandom};
            1: v = {8{8'h55}};
            2: v = '0;
            default: for (int i = 0; i < 8; i++) v[8*i +: 8] = ($urandom_range(0, 1) == 1) ? 8'h55 : 8'hAA;
        endcase
        return v;
    endfunction

    function automatic void ilas_octet(input int m, input int j, output logic [7:0] o, output bit c);
        logic [111:0] t;
        c = 1'b0;
        o = 8'(j);
        if (j == 0) begin
            o = 8'h1C; c = 1'b1;
        end else if (j == fk - 1) begin
            o = 8'h7C; c = 1'b1;
        end else if (m == 1 && j == 1) begin
            o = 8'h9C; c = 1'b1;
        end else if (m == 1 && j >= 2 && j <= 15) begin
            t = cfg >> (8 * (j - 2));
            o = t[7:0];
        end
    endfunction

    function automatic void model_start_data(input bit scr);
        logic [14:0] seed;
        seed   = 15'h7F80;
        m_prev = 8'h7C;
        m_rep  = 1'b1;
        m_scr  = scr;
        m_j    = 0;
        hist.delete();
        for (int b = 14; b >= 0; b--) hist.push_back(seed[b]);
    endfunction

    function automatic void model_octet(input logic [7:0] d, output logic [7:0] o, output bit c);
        bit fe, me, nbit;
        fe = (m_j % f) == f - 1;
        me = (m_j == fk - 1);
        o  = d;
        c  = 1'b0;
        if (m_scr) begin
            for (int b = 7; b >= 0; b--) begin
                nbit = d[b] ^ hist[hist.size() - 14] ^ hist[hist.size() - 15];
                o[b] = nbit;
                hist.push_back(nbit);
                void'(hist.pop_front());
            end
            c = fe && ((o == 8'hFC) || (me && o == 8'h7C));
        end else if (fe) begin
            if (me && d == m_prev) begin
                o = 8'h7C; c = 1'b1; m_rep = 1'b1;
            end else if (!me && d == m_prev && !m_rep) begin
                o = 8'hFC; c = 1'b1; m_rep = 1'b1;
            end else begin
                m_rep = 1'b0;
            end
            m_prev = d;
        end
        m_j = (m_j + 1) % fk;
    endfunction

    // Brings the link up and checks every ILAS beat; returns in the cycle showing the last ILAS beat.
    task automatic link_up(input bit scr);
        logic [63:0] ed;
        logic [7:0]  ec, eo;
        logic        er;
        bit          c;
        int          nb, j;
        set_sync(1'b1);
        step(); step(); step();
        set_lmfc(1'b1);
        step();
        set_lmfc(1'b0);
        nb = 4 * fk / opb;
        for (int b = 0; b < nb; b++) begin
            ed = '0;
            ec = '0;
            for (int i = 0; i < opb; i++) begin
                j = b * opb + i;
                ilas_octet(j / fk, j % fk, eo, c);
                ed[8*i +: 8] = eo;
                ec[i]        = c;
            end
            er = (b == nb - 1);
            checks++;
            if (obs_data() !== ed) begin
                errors++; $display("FAIL ilas_data beat %0d: got %h expected %h", b, obs_data(), ed);
            end
            checks++;
            if (obs_ctrl() !== ec) begin
                errors++; $display("FAIL ilas_ctrl beat %0d: got %b expected %b", b, obs_ctrl(), ec);
            end
            checks++;
            if (obs_state() !== 2'd1) begin
                errors++; $display("FAIL ilas_state beat %0d: got %0d expected 1", b, obs_state());
            end
            checks++;
            if (obs_ready() !== er) begin
                errors++; $display("FAIL ilas_ready beat %0d: got %b expected %b", b, obs_ready(), er);
            end
            if (b < nb - 1) begin
                drive(gen(0));
                step();
            end
        end
        scramble_en = scr;
        model_start_data(scr);
    endtask

    task automatic data_run(input int n, input int mode);
        logic [63:0] d, ed;
        logic [7:0]  ec, eo;
        bit          c;
        for (int k = 0; k < n; k++) begin
            d  = gen(mode);
            ed = '0;
            ec = '0;
            checks++;
            if (obs_ready() !== 1'b1) begin
                errors++; $display("FAIL data_ready beat %0d: got %b expected 1", k, obs_ready());
            end
            for (int i = 0; i < opb; i++) begin
                model_octet(d[8*i +: 8], eo, c);
                ed[8*i +: 8] = eo;
                ec[i]        = c;
            end
            drive(d);
            step();
            checks++;
            if (obs_data() !== ed) begin
                errors++; $display("FAIL data_out beat %0d: got %h expected %h", k, obs_data(), ed);
            end
            checks++;
            if (obs_ctrl() !== ec) begin
                errors++; $display("FAIL data_ctrl beat %0d: got %b expected %b", k, obs_ctrl(), ec);
            end
            checks++;
            if (obs_state() !== 2'd2) begin
                errors++; $display("FAIL data_state beat %0d: got %0d expected 2", k, obs_state());
            end
        end
    endtask

    task automatic check_cgs(input string tag);
        checks++;
        if (obs_data() !== k_data()) begin
            errors++; $display("FAIL %s data: got %h expected %h", tag, obs_data(), k_data());
        end
        checks++;
        if (obs_ctrl() !== k_ctrl()) begin
            errors++; $display("FAIL %s ctrl: got %b expected %b", tag, obs_ctrl(), k_ctrl());
        end
        checks++;
        if (obs_ready() !== 1'b0) begin
            errors++; $display("FAIL %s ready: got %b expected 0", tag, obs_ready());
        end
        checks++;
        if (obs_state() !== 2'd0) begin
            errors++; $display("FAIL %s state: got %0d expected 0", tag, obs_state());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step(); step();
        check_cgs("reset_held");
        reset = 1'b0;
        step();
        check_cgs("reset_released");
    endtask

    task automatic test_cgs();
        set_sync(1'b0);
        for (int k = 0; k < 100; k++) begin
            set_lmfc($urandom_range(0, 7) == 0);
            step();
            check_cgs("cgs");
        end
        set_lmfc(1'b0);
    endtask

    task automatic test_ilas_data();
        link_up(1'b0);
        data_run(64, 3);
    endtask

    task automatic test_sync_pulses();
        set_sync(1'b0);
        data_run(3, 0);
        set_sync(1'b1);
        data_run(6, 0);
        set_sync(1'b0);
        data_run(4, 0);
        checks++;
        if (obs_ready() !== 1'b0) begin
            errors++; $display("FAIL loss_ready: got %b expected 0", obs_ready());
        end
        checks++;
        if (obs_state() !== 2'd2) begin
            errors++; $display("FAIL loss_state_hold: got %0d expected 2", obs_state());
        end
        drive(gen(0));
        step();
        check_cgs("loss_k");
        set_sync(1'b1);
        step();
        check_cgs("loss_after");
    endtask

    task automatic test_const55();
        logic [63:0] d;
        logic [7:0]  eo;
        bit          c;
        link_up(1'b0);
        d = gen(1);
        for (int i = 0; i < opb; i++) model_octet(d[8*i +: 8], eo, c);
        drive(d);
        step();
        checks++;
        if (obs_data() !== 64'h00000000FC555555) begin
            errors++; $display("FAIL const55_first data: got %h expected fc555555", obs_data());
        end
        checks++;
        if (obs_ctrl() !== 8'b00001000) begin
            errors++; $display("FAIL const55_first ctrl: got %b expected 00001000", obs_ctrl());
        end
        data_run(40, 1);
    endtask

    task automatic test_scramble();
        set_sync(1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        link_up(1'b1);
        data_run(1, 2);
        scramble_en = 1'b0;
        data_run(63, 2);
        data_run(200, 0);
        reset = 1'b1;
        set_sync(1'b0);
        step();
        check_cgs("reset_mid_data");
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_ilas();
        set_sync(1'b1);
        step(); step(); step();
        set_lmfc(1'b1);
        step();
        set_lmfc(1'b0);
        step(); step(); step(); step();
        reset = 1'b1;
        set_sync(1'b0);
        step();
        check_cgs("reset_mid_ilas");
        reset = 1'b0;
        step();
        check_cgs("reset_mid_ilas_after");
    endtask

    task automatic test_wide();
        sel = 1; opb = 8; f = 1; fk = 32;
        step();
        check_cgs("wide_idle");
        link_up(1'b0);
        data_run(100, 3);
        data_run(20, 1);
    endtask

    initial begin
        cfg = {16'($urandom), $urandom, $urandom, $urandom};
        test_reset();
        test_cgs();
        test_ilas_data();
        test_sync_pulses();
        test_const55();
        test_scramble();
        test_reset_mid_ilas();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jesd204b_link_tx.md
JESD204B_LINK_TX -- requirements
Module: jesd204b_link_tx

Interface
REQ-001 SHALL have parameter OCTETS_PER_BEAT, default 4, octets per lane beat (legal: 4, 8).
REQ-002 SHALL have parameter F, default 2, octets per frame (legal: 1, 2, 4, 8).
REQ-003 SHALL have parameter K, default 16, frames per multiframe.
- F*K SHALL be a multiple of OCTETS_PER_BEAT and >= 20.
- Elaboration SHALL fail otherwise.
REQ-004 SHALL have parameter ILAS_MF, default 4, number of ILAS multiframes (legal 2..8).
REQ-005 Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous active-high reset.
- lmfc, input, 1: one-cycle pulse on the beat that starts a multiframe.
- sync_n, input, 1: receiver SYNC~, low requests resync.
- scramble_en, input, 1: sampled only on the ILAS->DATA transition.
- cfg, input, 112: ILAS link configuration octets 0..13, octet n in [8n+7:8n].
- in_data, input, 8*OCTETS_PER_BEAT: user data.
- in_ready, output, 1: high when in_data is consumed this beat.
- out_data, output, 8*OCTETS_PER_BEAT: lane octets.
- out_ctrl, output, OCTETS_PER_BEAT: per-octet K-character flag.
- link_state, output, 2: current state, encoded CGS=0, ILAS=1, DATA=2.
REQ-006 Octet ordering SHALL place octet 0 (earliest in time) in bits [7:0] on all data buses.

Function
REQ-007 State machine SHALL have states CGS, ILAS and DATA, plus a single-cycle internal flag wait_lmfc inside CGS.
REQ-008 CGS: out_data SHALL be 0xBC in every octet, out_ctrl all ones, in_ready 0.
REQ-009 In CGS, when sync_n is high, the block SHALL set wait_lmfc.
- On the first lmfc with wait_lmfc set and sync_n high, the block SHALL enter ILAS.
- The beat on which lmfc pulses SHALL be ILAS octet 0.
REQ-010 ILAS SHALL emit ILAS_MF multiframes of F*K octets each, at mf index m and octet index j:
- j=0: 0x1C (/R/), ctrl=1.
- j=F*K-1: 0x7C (/A/), ctrl=1.
- m=1 only, j=1: 0x9C (/Q/), ctrl=1.
- m=1 only, j=2..15: cfg octet j-2, ctrl=0.
- All other octets: j[7:0], ctrl=0.
REQ-011 After the last ILAS octet, the block SHALL enter DATA with in_ready=1 on that same transition cycle.
REQ-012 DATA latency: in_data accepted on cycle n SHALL appear on out_data on cycle n+1, with exactly one register stage.
REQ-013 A frame/multiframe octet counter SHALL run continuously from ILAS start.
- It SHALL wrap at F*K.
- An lmfc pulse disagreeing with the counter SHALL be ignored, with no realignment.
REQ-014 Scrambling off, character replacement at the last octet of each frame:
- At the multiframe end, if the octet equals the last octet of the previous frame (pre-replacement value), it SHALL be sent as 0x7C with ctrl=1.
- Otherwise, if it equals the previous frame last octet and that previous octet was not replaced, it SHALL be sent as 0xFC with ctrl=1.
- Else it SHALL be sent unchanged with ctrl=0.
REQ-015 The previous-frame tracking of REQ-014 SHALL work across beat boundaries and with multiple frame ends per beat (F < OCTETS_PER_BEAT).
- Within a beat, octets SHALL be processed in ascending order.
REQ-016 For the first DATA frame, the "previous frame" SHALL be taken as the ILAS /A/ slot value 0x7C with replaced=1.
REQ-017 Scrambling on:
- Octets SHALL pass through a self-synchronous scrambler 1+x^14+x^15, MSB first, with 15-bit state set to 0x7F80 on DATA entry.
- At the frame end, a scrambled octet equal to 0xFC, or 0x7C at multiframe end, SHALL be flagged ctrl=1 with the value unchanged.
- All other octets SHALL have ctrl=0.
REQ-018 sync_n low for 4 or more consecutive cycles in ILAS or DATA SHALL return the block to CGS.
- in_ready SHALL drop on the next cycle.
- /K/ output SHALL begin the cycle after.
- Shorter low pulses SHALL be ignored.
REQ-019 link_state SHALL be registered and SHALL change in the same cycle out_data begins the new state's pattern.

Reset
REQ-020 While reset is high, the block SHALL force state CGS with wait_lmfc clear and all counters, scrambler and previous-frame registers cleared.
REQ-021 Output values during and after reset:
- out_data SHALL be all-0xBC.
- out_ctrl SHALL be all ones.
- in_ready SHALL be 0.
- link_state SHALL be 0.
REQ-022 Reset asserted mid-ILAS or mid-DATA SHALL take effect on the next clock edge with no completion of the frame in progress.

Verification
REQ-023 Default params, sync_n held low 100 cycles -> every beat 0xBCBCBCBC, out_ctrl 4'hF, in_ready 0.
REQ-024 sync_n rises, lmfc pulse 3 cycles later -> 4 multiframes (32 beats); first beat 0x0302011C ctrl 4'b0001; MF1 beat 0 = {cfg1,cfg0,0x9C,0x1C} ctrl 4'b0011; each MF last octet 0x7C; DATA begins on beat 33.
REQ-025 Scrambling off, F=2, in_data 0x55555555 constant -> octet 1 of every frame replaced; pattern alternates 0xFC (ctrl=1) then 0x55 (ctrl=0); octet 31 of each MF = 0x7C whenever original 0x55 matches.
REQ-026 Scrambling on, in_data 0 -> out_data matches golden scrambler model starting at state 0x7F80; ctrl=1 exactly where frame-end scrambled octets equal 0xFC/0x7C.
REQ-027 In DATA, pulse sync_n low 3 cycles -> no change; low 5 cycles -> in_ready=0 after the 4th low cycle, /K/ next beat, link_state=0.
REQ-028 OCTETS_PER_BEAT=8, F=1, K=32, scrambling off, alternating equal data -> eight frame-end decisions per beat match REQ-014 reference model.
